// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - captures count on done, converts to BCD by double dabble,
// and scans three digits onto a 4-anode seven-segment display with leading-zero blanking.
module count_bcd_display #(
  parameter int CNT_W          = 7,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [CNT_W-1:0] count,
  input  logic             done,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy,
  output logic             valid
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t           state;
  logic             done_q;
  logic [CNT_W-1:0] bin;
  logic [11:0]      bcd;
  logic [11:0]      bcd_adj;
  logic [3:0]       iter;
  logic [11:0]      dig;
  logic [RW-1:0]    rcnt;
  logic [1:0]       sel;
  logic             capture;

  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  assign capture = done & ~done_q & (state == IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      bin    <= '0;
      bcd    <= '0;
      iter   <= '0;
      dig    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      done_q <= done;
      case (state)
        IDLE: if (capture) begin
          bin   <= count;
          bcd   <= '0;
          iter  <= '0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          bcd  <= {bcd_adj[10:0], bin[CNT_W-1]};
          bin  <= bin << 1;
          iter <= iter + 4'd1;
          if (iter == 4'(CNT_W - 1)) state <= LOAD;
        end
        LOAD: begin
          dig   <= bcd;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit slot advances each time the refresh counter wraps; slot 3 is never visited.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rcnt <= '0;
      sel  <= 2'd0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      sel  <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  always_comb begin
    nib     = 4'd0;
    blank   = 1'b1;
    seg_nxt = SEG_OFF;
    an_nxt  = 4'b1111;
    case (sel)
      2'd0: begin nib = dig[3:0];  blank = 1'b0; end
      2'd1: begin nib = dig[7:4];  blank = (dig[11:8] == 4'd0) && (dig[7:4] == 4'd0); end
      2'd2: begin nib = dig[11:8]; blank = (dig[11:8] == 4'd0); end
      default: begin nib = 4'd0; blank = 1'b1; end
    endcase
    if (valid && !blank) begin
      an_nxt  = ~(4'b0001 << sel);
      seg_nxt = SEG_ACTIVE_LOW ? ~decode(nib) : decode(nib);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      seg <= SEG_OFF;
      an  <= 4'b1111;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - scoreboard bench: stimulus queues expected digits per
// conversion, a negedge monitor checks busy length and the scanned display per conversion.
module tb_count_bcd_display;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [6:0] count = '0;
  logic       done = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       valid;

  count_bcd_display #(.CNT_W(7), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .count(count), .done(done),
    .seg(seg), .an(an), .busy(busy), .valid(valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int c;
    int h;
    int t;
    int o;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_busy = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Active-low gfedcba patterns, written out by hand.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Monitor: a busy falling edge outside reset marks a finished conversion.
  initial begin
    int   bc;
    logic pb;
    exp_t e;
    bc = 0;
    pb = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        bc = 0;
        pb = 1'b0;
      end else begin
        if (busy) bc++;
        if (pb && !busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_conversion", 1, 0);
          end else begin
            int n_one, n_ten, n_hun, n_blk;
            e = sb.pop_front();
            mon_busy = 1'b1;
            chk($sformatf("busy_cycles_%0d", e.c), bc, 8);
            chk($sformatf("valid_%0d", e.c), int'(valid), 1);
            n_one = 0; n_ten = 0; n_hun = 0; n_blk = 0;
            for (int i = 0; i < 12; i++) begin
              @(negedge Clk);
              case (an)
                4'b1110: begin n_one++; chk($sformatf("seg_ones_%0d", e.c), int'(seg), int'(seg_of(e.o))); end
                4'b1101: begin n_ten++; chk($sformatf("seg_tens_%0d", e.c), int'(seg), int'(seg_of(e.t))); end
                4'b1011: begin n_hun++; chk($sformatf("seg_hund_%0d", e.c), int'(seg), int'(seg_of(e.h))); end
                4'b1111: begin n_blk++; chk($sformatf("seg_blank_%0d", e.c), int'(seg), 7'h7F); end
                default: chk($sformatf("an_illegal_%0d", e.c), int'(an), 4'b1111);
              endcase
            end
            chk($sformatf("ones_slots_%0d", e.c), n_one, 4);
            chk($sformatf("tens_slots_%0d", e.c), n_ten, (e.h != 0 || e.t != 0) ? 4 : 0);
            chk($sformatf("hund_slots_%0d", e.c), n_hun, (e.h != 0) ? 4 : 0);
            chk($sformatf("blank_slots_%0d", e.c), n_blk,
                ((e.h == 0) ? 4 : 0) + ((e.h == 0 && e.t == 0) ? 4 : 0));
            mon_busy = 1'b0;
          end
          bc = 0;
        end
        pb = busy;
      end
    end
  end

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk);
      if (sb.size() == 0 && !mon_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_timeout"}, int'(ok), 1);
  endtask

  task automatic convert(input int c, input int h, input int t, input int o);
    exp_t e;
    e.c = c; e.h = h; e.t = t; e.o = o;
    sb.push_back(e);
    @(posedge Clk); #1;
    count = 7'(c);
    done  = 1'b1;
    @(posedge Clk); #1;
    done  = 1'b0;
    wait_idle($sformatf("conv_%0d", c));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_an"},    int'(an),    4'b1111);
    chk({name, "_seg"},   int'(seg),   7'h7F);
    chk({name, "_busy"},  int'(busy),  0);
    chk({name, "_valid"}, int'(valid), 0);
  endtask

  initial begin
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Rst = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      check_reset_outputs("post_reset");
    end

    convert(45, 0, 4, 5);
    convert(127, 1, 2, 7);
    convert(0, 0, 0, 0);

    // Held done with a re-rise during CONV and a count change after capture.
    begin
      exp_t e;
      e.c = 63; e.h = 0; e.t = 6; e.o = 3;
      sb.push_back(e);
      @(posedge Clk); #1;
      count = 7'd63;
      done  = 1'b1;
      for (int k = 1; k < 20; k++) begin
        @(posedge Clk); #1;
        if (k == 3)  done  = 1'b0;
        if (k == 4)  done  = 1'b1;
        if (k == 10) count = 7'd99;
      end
      done = 1'b0;
      wait_idle("held_done");
      repeat (10) begin
        @(negedge Clk);
        chk("held_no_second_conv", int'(busy), 0);
      end
    end

    // Reset in the middle of a conversion of 88.
    @(posedge Clk); #1;
    count = 7'd88;
    done  = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("mid_conv_busy", int'(busy), 1);
    Rst  = 1'b1;
    done = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    repeat (14) begin
      @(negedge Clk);
      check_reset_outputs("after_mid_reset");
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
